// File: rtl/dev_reshuffler_tile.sv
// dev_reshuffler_tile: CSR-programmed tile reshuffler.
// Collects SpatPar input beats into a SpatPar x SpatPar tile buffer. The tile is then
// drained as SpatPar output beats in identity, transpose or lane-reverse order.
// Runs repeat for NUM_TILES tiles.
module dev_reshuffler_tile #(
    parameter int SpatPar      = 8,
    parameter int ElemWidth    = 8,
    parameter int RegCount     = 8,
    parameter int RegDataWidth = 32,
    parameter int RegAddrWidth = $clog2(RegCount)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [SpatPar*ElemWidth-1:0]  a_i,
    input  logic                          a_valid_i,
    output logic                          a_ready_o,
    output logic [SpatPar*ElemWidth-1:0]  z_o,
    output logic                          z_valid_o,
    input  logic                          z_ready_i,
    input  logic [RegAddrWidth-1:0]       csr_addr_i,
    input  logic [RegDataWidth-1:0]       csr_wr_data_i,
    input  logic                          csr_wr_en_i,
    input  logic                          csr_req_valid_i,
    output logic                          csr_req_ready_o,
    output logic [RegDataWidth-1:0]       csr_rd_data_o,
    output logic                          csr_rsp_valid_o,
    input  logic                          csr_rsp_ready_i
);

    localparam int unsigned CntW = (SpatPar > 1) ? $clog2(SpatPar) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(SpatPar - 1);

    localparam logic [RegAddrWidth-1:0] AddrMode      = RegAddrWidth'(0);
    localparam logic [RegAddrWidth-1:0] AddrNumTiles  = RegAddrWidth'(1);
    localparam logic [RegAddrWidth-1:0] AddrStart     = RegAddrWidth'(2);
    localparam logic [RegAddrWidth-1:0] AddrStatus    = RegAddrWidth'(3);
    localparam logic [RegAddrWidth-1:0] AddrTilesDone = RegAddrWidth'(4);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [1:0]              mode_reg;
    logic [1:0]              mode_run;
    logic [RegDataWidth-1:0] num_tiles;
    logic [RegDataWidth-1:0] tiles_done;
    logic [RegDataWidth-1:0] tiles_left;
    logic [CntW-1:0]         beat_cnt;
    logic [ElemWidth-1:0]    tile_buf [SpatPar][SpatPar];

    logic                    rsp_valid;
    logic [RegDataWidth-1:0] rd_data;
    logic [RegDataWidth-1:0] rd_mux;

    logic csr_hs, wr_hs, rd_hs;
    logic idle, start;
    logic fill_hs, drain_hs;

    assign csr_req_ready_o = !rsp_valid;
    assign csr_rsp_valid_o = rsp_valid;
    assign csr_rd_data_o   = rd_data;

    assign csr_hs   = csr_req_valid_i && csr_req_ready_o;
    assign wr_hs    = csr_hs && csr_wr_en_i;
    assign rd_hs    = csr_hs && !csr_wr_en_i;
    assign idle     = (state == IDLE);
    assign start    = wr_hs && idle && (csr_addr_i == AddrStart) && csr_wr_data_i[0]
                      && (num_tiles != '0);
    // Handshakes derived from state and inputs so the FSM process never reads its own outputs
    assign fill_hs  = (state == FILL) && a_valid_i;
    assign drain_hs = (state == DRAIN) && z_ready_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and stream handshake outputs
    always_comb begin
        state_next = state;
        a_ready_o  = 1'b0;
        z_valid_o  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FILL;
            end
            FILL: begin
                a_ready_o = 1'b1;
                if (a_valid_i && (beat_cnt == LastBeat)) state_next = DRAIN;
            end
            DRAIN: begin
                z_valid_o = 1'b1;
                if (z_ready_i && (beat_cnt == LastBeat)) begin
                    state_next = (tiles_left == RegDataWidth'(1)) ? IDLE : FILL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter and run bookkeeping (mode latch, tile counters)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt   <= '0;
            mode_run   <= '0;
            tiles_done <= '0;
            tiles_left <= '0;
        end else begin
            if (fill_hs || drain_hs) begin
                beat_cnt <= (beat_cnt == LastBeat) ? '0 : beat_cnt + 1'b1;
            end
            if (start) begin
                mode_run   <= mode_reg;
                tiles_done <= '0;
                tiles_left <= num_tiles;
            end else if (drain_hs && (beat_cnt == LastBeat)) begin
                tiles_done <= tiles_done + 1'b1;
                tiles_left <= tiles_left - 1'b1;
            end
        end
    end

    // Tile buffer row write on each accepted input beat
    always_ff @(posedge clk_i) begin
        if (fill_hs) begin
            for (int unsigned c = 0; c < SpatPar; c++) begin
                tile_buf[beat_cnt][CntW'(c)] <= a_i[c*ElemWidth +: ElemWidth];
            end
        end
    end

    // Output beat permutation; driven to zero outside DRAIN
    always_comb begin
        z_o = '0;
        if (state == DRAIN) begin
            for (int unsigned c = 0; c < SpatPar; c++) begin
                case (mode_run)
                    2'd1:    z_o[c*ElemWidth +: ElemWidth] = tile_buf[CntW'(c)][beat_cnt];
                    2'd2:    z_o[c*ElemWidth +: ElemWidth] = tile_buf[beat_cnt][CntW'(SpatPar - 1 - c)];
                    default: z_o[c*ElemWidth +: ElemWidth] = tile_buf[beat_cnt][CntW'(c)];
                endcase
            end
        end
    end

    // CSR read data select
    always_comb begin
        rd_mux = '0;
        case (csr_addr_i)
            AddrMode:      rd_mux = RegDataWidth'(mode_reg);
            AddrNumTiles:  rd_mux = num_tiles;
            AddrStatus:    rd_mux = RegDataWidth'(!idle);
            AddrTilesDone: rd_mux = tiles_done;
            default:       rd_mux = '0;
        endcase
    end

    // CSR writable registers and registered read response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_reg  <= '0;
            num_tiles <= '0;
            rsp_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (wr_hs && idle) begin
                if (csr_addr_i == AddrMode)     mode_reg  <= csr_wr_data_i[1:0];
                if (csr_addr_i == AddrNumTiles) num_tiles <= csr_wr_data_i;
            end
            if (rd_hs) begin
                rsp_valid <= 1'b1;
                rd_data   <= rd_mux;
            end else if (rsp_valid && csr_rsp_ready_i) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dev_reshuffler_tile.sv
// tb_dev_reshuffler_tile: directed stimulus with scoreboard queues for z beats and CSR reads.
module tb_dev_reshuffler_tile;

    localparam int SP = 4;
    localparam int EW = 8;
    localparam int DW = 32;
    localparam int AW = 3;

    logic            clk;
    logic            rst_n;
    logic [SP*EW-1:0] a;
    logic            a_valid;
    logic            a_ready;
    logic [SP*EW-1:0] z;
    logic            z_valid;
    logic            z_ready = 1'b1;
    logic [AW-1:0]   csr_addr;
    logic [DW-1:0]   csr_wdata;
    logic            csr_we;
    logic            csr_valid;
    logic            csr_req_ready;
    logic [DW-1:0]   csr_rdata;
    logic            csr_rsp_valid;
    logic            csr_rsp_ready;

    dev_reshuffler_tile #(
        .SpatPar(SP),
        .ElemWidth(EW),
        .RegCount(8),
        .RegDataWidth(DW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .a_i(a),
        .a_valid_i(a_valid),
        .a_ready_o(a_ready),
        .z_o(z),
        .z_valid_o(z_valid),
        .z_ready_i(z_ready),
        .csr_addr_i(csr_addr),
        .csr_wr_data_i(csr_wdata),
        .csr_wr_en_i(csr_we),
        .csr_req_valid_i(csr_valid),
        .csr_req_ready_o(csr_req_ready),
        .csr_rd_data_o(csr_rdata),
        .csr_rsp_valid_o(csr_rsp_valid),
        .csr_rsp_ready_i(csr_rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_pass  = 0;

    logic [31:0] z_exp [$];
    logic [31:0] csr_exp [$];
    string       csr_name [$];

    int   in_cnt = 0;
    int   out_cnt = 0;
    int   stall_cnt = 0;
    bit   toggle_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_z = '0;

    localparam logic [127:0] IN_WORDS = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks_total++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // z_ready: constant 1, or toggling each cycle while backpressure is enabled
    always @(posedge clk) begin
        #1;
        if (toggle_en) z_ready = ~z_ready;
        else           z_ready = 1'b1;
    end

    // Monitor: samples at negedge, a handshake seen here completes at the next posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check32("z_hold_data", z, prev_z);
                check32("z_hold_valid", 32'(z_valid), 32'd1);
            end
            prev_stall = z_valid && !z_ready;
            prev_z = z;
            if (prev_stall) stall_cnt++;
            if (z_valid && z_ready) begin
                out_cnt++;
                if (z_exp.size() == 0) fail_now("z_unexpected");
                else check32("z_beat", z, z_exp.pop_front());
            end
            if (a_valid && a_ready) in_cnt++;
            if (csr_rsp_valid && csr_rsp_ready) begin
                if (csr_exp.size() == 0) fail_now("csr_rsp_unexpected");
                else check32(csr_name.pop_front(), csr_rdata, csr_exp.pop_front());
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic csr_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit hs;
        hs = 1'b0;
        csr_valid = 1'b1;
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = data;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (csr_req_ready) hs = 1'b1;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        if (!hs) fail_now("csr_req_timeout");
        csr_valid = 1'b0;
        csr_we    = 1'b0;
    endtask

    task automatic csr_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        csr_req(1'b1, addr, data);
    endtask

    task automatic csr_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        csr_exp.push_back(exp);
        csr_name.push_back(name);
        csr_req(1'b0, addr, '0);
    endtask

    task automatic send_beat(input logic [31:0] word, input bit lat_chk);
        bit hs;
        hs = 1'b0;
        a_valid = 1'b1;
        a = word;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (a_ready) begin
                hs = 1'b1;
                if (lat_chk) check32("z_valid_before_last_in", 32'(z_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            if (hs) break;
        end
        if (!hs) fail_now("a_handshake_timeout");
        if (hs && lat_chk) check32("z_valid_cycle_after_last_in", 32'(z_valid), 32'd1);
    endtask

    task automatic feed_tiles(input int n, input bit lat_chk);
        logic [127:0] w;
        w = IN_WORDS;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < SP; i++) begin
                send_beat(w[i*32 +: 32], lat_chk && (i == SP - 1));
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic push_z(input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] b2, input logic [31:0] b3);
        z_exp.push_back(b0);
        z_exp.push_back(b1);
        z_exp.push_back(b2);
        z_exp.push_back(b3);
    endtask

    task automatic wait_z_empty();
        for (int t = 0; t < 300 && z_exp.size() != 0; t++) @(posedge clk);
        if (z_exp.size() != 0) fail_now("z_drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_csr_empty();
        for (int t = 0; t < 100 && csr_exp.size() != 0; t++) @(posedge clk);
        if (csr_exp.size() != 0) fail_now("csr_drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in(input int target);
        for (int t = 0; t < 400 && in_cnt < target; t++) @(negedge clk);
        if (in_cnt < target) fail_now("in_count_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int in_base;
        int out_base;
        int stall_base;

        rst_n = 1'b0;
        a = '0;
        a_valid = 1'b0;
        csr_addr = '0;
        csr_wdata = '0;
        csr_we = 1'b0;
        csr_valid = 1'b0;
        csr_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_a_ready", 32'(a_ready), 32'd0);
        check32("rst_z_valid", 32'(z_valid), 32'd0);
        check32("rst_z", z, 32'd0);
        check32("rst_req_ready", 32'(csr_req_ready), 32'd1);
        check32("rst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        check32("rst_rd_data", csr_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity, single tile
        csr_write(3'd0, 32'd0);
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd1);
        push_z(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        feed_tiles(1, 1'b0);
        wait_z_empty();
        csr_read(3'd4, 32'd1, "id_tiles_done");
        csr_read(3'd3, 32'd0, "id_status");

        // Transpose with first-beat latency check
        csr_write(3'd0, 32'd1);
        csr_write(3'd2, 32'd1);
        push_z(32'h0C080400, 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703);
        feed_tiles(1, 1'b1);
        wait_z_empty();

        // Lane-reverse under toggling z_ready
        csr_write(3'd0, 32'd2);
        csr_write(3'd2, 32'd1);
        push_z(32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F);
        stall_base = stall_cnt;
        toggle_en = 1'b1;
        feed_tiles(1, 1'b0);
        wait_z_empty();
        toggle_en = 1'b0;
        check32("rev_stalls_seen", 32'(stall_cnt > stall_base), 32'd1);
        wait_csr_empty();

        // Multi-tile run with mid-run CSR traffic
        csr_write(3'd0, 32'd0);
        csr_write(3'd1, 32'd3);
        csr_write(3'd2, 32'd1);
        for (int t = 0; t < 3; t++) push_z(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        in_base = in_cnt;
        out_base = out_cnt;
        fork
            feed_tiles(3, 1'b0);
            begin
                wait_in(in_base + 1);
                csr_read(3'd4, 32'd0, "multi_tiles_done_0");
                csr_read(3'd3, 32'd1, "multi_status_busy");
                wait_in(in_base + 5);
                csr_read(3'd4, 32'd1, "multi_tiles_done_1");
                csr_write(3'd0, 32'd1);
                wait_in(in_base + 9);
                csr_read(3'd4, 32'd2, "multi_tiles_done_2");
            end
        join
        wait_z_empty();
        wait_csr_empty();
        check32("multi_in_beats", 32'(in_cnt - in_base), 32'd12);
        check32("multi_out_beats", 32'(out_cnt - out_base), 32'd12);
        csr_read(3'd0, 32'd0, "multi_mode_write_ignored");
        csr_read(3'd4, 32'd3, "multi_tiles_done_final");

        // START with NUM_TILES == 0
        csr_write(3'd1, 32'd0);
        csr_write(3'd2, 32'd1);
        csr_read(3'd3, 32'd0, "zero_tiles_status");
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            check32("zero_tiles_a_ready", 32'(a_ready), 32'd0);
        end
        wait_csr_empty();

        // Reset asserted after two input beats
        csr_write(3'd0, 32'd2);
        csr_write(3'd1, 32'd1);
        csr_write(3'd2, 32'd1);
        send_beat(32'h03020100, 1'b0);
        send_beat(32'h07060504, 1'b0);
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("midrst_a_ready", 32'(a_ready), 32'd0);
        check32("midrst_z_valid", 32'(z_valid), 32'd0);
        check32("midrst_z", z, 32'd0);
        check32("midrst_req_ready", 32'(csr_req_ready), 32'd1);
        check32("midrst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        csr_read(3'd0, 32'd0, "midrst_mode");
        csr_read(3'd3, 32'd0, "midrst_status");
        csr_read(3'd4, 32'd0, "midrst_tiles_done");

        // Unmapped address
        csr_write(3'd6, 32'hFFFF_FFFF);
        csr_read(3'd6, 32'd0, "addr6_read");
        csr_read(3'd2, 32'd0, "start_read");

        wait_csr_empty();
        check32("z_queue_empty", 32'(z_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/dev_reshuffler_tile.md
Name: dev_reshuffler_tile

Overview:
CSR-programmed, tile-buffered data reshuffler for the dev accelerator tiles.
- Collects SpatPar input beats of SpatPar elements each into an internal SpatPar x SpatPar tile buffer.
- Drains the tile as SpatPar output beats using a CSR-selected permutation: identity, transpose, or lane-reverse.
- Processes a CSR-programmed number of tiles per run.
- Sits between a streamer read port and a streamer write port; owns its own CSR register file and handshake.

Parameters:
SpatPar, 8, elements per beat and beats per tile (tile is SpatPar x SpatPar).
ElemWidth, 8, bits per element.
RegCount, 8, number of CSR addresses decoded.
RegDataWidth, 32, CSR data width.
RegAddrWidth, $clog2(RegCount), CSR address width.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
a_i  in  SpatPar*ElemWidth  input beat; lane c = a_i[c*ElemWidth +: ElemWidth].
a_valid_i  in  1  input beat valid.
a_ready_o  out  1  input beat ready.
z_o  out  SpatPar*ElemWidth  output beat, same lane packing as a_i.
z_valid_o  out  1  output beat valid.
z_ready_i  in  1  output beat ready.
csr_addr_i  in  RegAddrWidth  CSR address.
csr_wr_data_i  in  RegDataWidth  CSR write data.
csr_wr_en_i  in  1  1 = write, 0 = read.
csr_req_valid_i  in  1  CSR request valid.
csr_req_ready_o  out  1  CSR request ready.
csr_rd_data_o  out  RegDataWidth  CSR read data.
csr_rsp_valid_o  out  1  CSR read response valid.
csr_rsp_ready_i  in  1  CSR read response ready.

Behaviour:
- Reset: asynchronous, active-low (rst_ni). All outputs 0 except csr_req_ready_o = 1. FSM goes to IDLE. MODE = 0, NUM_TILES = 0, TILES_DONE = 0. Tile buffer is not reset.
- CSR map:
  - 0 MODE [1:0], RW: 0 identity, 1 transpose, 2 lane-reverse, 3 treated as identity.
  - 1 NUM_TILES, RW.
  - 2 START, WO: any write with bit0 = 1 starts a run; reads return 0.
  - 3 STATUS, RO: bit0 = busy (FSM != IDLE).
  - 4 TILES_DONE, RO.
  - Addresses 5..7: reads return 0; writes are ignored.
- CSR handshake:
  - A request is accepted on req_valid && req_ready.
  - Writes take effect on the following edge and produce no response.
  - A read registers its data, and rsp_valid rises the next cycle. rsp_valid and rd_data are held until rsp_ready.
  - req_ready = 0 while a read response is pending; a response and its retirement in the same cycle re-enable ready the next cycle.
- Writes to MODE or NUM_TILES while busy are ignored. A START write while busy is ignored.
- FSM:
  - IDLE -> FILL on START when NUM_TILES != 0. This clears TILES_DONE and loads the remaining-tile counter.
  - START with NUM_TILES == 0 is a no-op; STATUS stays 0.
  - FILL: a_ready_o = 1, z_valid_o = 0. Each accepted beat writes buffer row r (beat counter 0..SpatPar-1). After row SpatPar-1 is accepted -> DRAIN.
  - DRAIN: a_ready_o = 0, z_valid_o = 1. Beat r, lane c:
    - identity: buf[r][c]
    - transpose: buf[c][r]
    - lane-reverse: buf[r][SpatPar-1-c]
  - z_o is stable while z_valid_o && !z_ready_i. The beat counter advances only on z_valid_o && z_ready_i.
  - After drain beat SpatPar-1 is accepted: TILES_DONE increments and the remaining-tile counter decrements. The FSM then goes to FILL if tiles remain, else IDLE.
  - A tile always completes fully; there is no partial-tile flush.
- Latency: the first z beat is valid in the cycle after the last a beat of the tile is accepted. Throughput is one tile per 2*SpatPar cycles with no backpressure.
- MODE is sampled at START and held for the whole run.
- a_valid_i is ignored outside FILL. z_ready_i is ignored outside DRAIN.
- Reset asserted mid-run: immediate return to IDLE with reset values; the in-flight tile is discarded.
- Counter widths: NUM_TILES, TILES_DONE and the remaining-tile counter are RegDataWidth bits. Beat counters are $clog2(SpatPar) bits and wrap to 0 at the end of each phase.

Test Plan:
- Bench parameters: SpatPar=4, ElemWidth=8.
- Identity: MODE=0, NUM_TILES=1, START; feed beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> the same four words out in order. TILES_DONE reads 1 and STATUS reads 0 afterwards.
- Transpose: MODE=1, same input -> z beats 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703. The first z_valid_o occurs the cycle after the 4th input beat is accepted.
- Lane-reverse with backpressure: MODE=2, z_ready_i toggling 1/0 -> first beat 0x00010203 is held stable during stall cycles; the output sequence is unchanged.
- Multi-tile: NUM_TILES=3, continuous valid/ready -> 24 handshakes total (12 in, 12 out). A mid-run STATUS read returns 1 and a mid-run TILES_DONE read increments 0->1->2. A mid-run write MODE=1 is ignored.
- Edge cases:
  - START with NUM_TILES=0 -> STATUS stays 0 and a_ready_o stays 0.
  - Reset pulsed after 2 input beats -> all outputs 0 and MODE reads 0.
  - A read to address 6 returns 0.
